vector_lane_dispatcher: RTL and testbench

//  Multi-lane successor to the single vector lane: sequences one vector op of vl elements across NUM_LANES lanes.
//  - Issues element groups of NUM_LANES, honours mask, absorbs variable lane latency (mul/div), collects results.
//  - Presents one writeback beat per group to the vector register file.
//  - Sits between vector decode/execute control and the lane array.

---
 rtl/vector_lane_dispatcher_if.sv | 34 +++
 rtl/vector_lane_dispatcher.sv | 108 ++++++++++
 tb/tb_vector_lane_dispatcher.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/vector_lane_dispatcher_if.sv
// vector_lane_dispatcher_if: op control, lane-array and register-file writeback bundle.
interface vector_lane_dispatcher_if #(
    parameter int NUM_LANES = 2,
    parameter int ELEN      = 32,
    parameter int VLMAX     = 32
);
    localparam int IDX_W = $clog2(VLMAX);
    localparam int VL_W  = $clog2(VLMAX + 1);
    logic                      start;
    logic [VL_W-1:0]           vl;
    logic                      mask_en;
    logic [VLMAX-1:0]          mask;
    logic                      busy;
    logic                      done;
    logic                      exception;
    logic [NUM_LANES-1:0]      lane_start;
    logic [NUM_LANES*IDX_W-1:0] lane_idx;
    logic [NUM_LANES-1:0]      lane_done;
    logic [NUM_LANES*ELEN-1:0] lane_result;
    logic [NUM_LANES-1:0]      lane_exception;
    logic                      wb_valid;
    logic                      wb_ready;
    logic [IDX_W-1:0]          wb_base_idx;
    logic [NUM_LANES-1:0]      wb_en;
    logic [NUM_LANES*ELEN-1:0] wb_data;
    modport master (
        input  start, vl, mask_en, mask, lane_done, lane_result, lane_exception, wb_ready,
        output busy, done, exception, lane_start, lane_idx, wb_valid, wb_base_idx, wb_en, wb_data
    );
    modport slave (
        output start, vl, mask_en, mask, lane_done, lane_result, lane_exception, wb_ready,
        input  busy, done, exception, lane_start, lane_idx, wb_valid, wb_base_idx, wb_en, wb_data
    );
endinterface

// File: rtl/vector_lane_dispatcher.sv
// vector_lane_dispatcher: sequences one vector op across NUM_LANES lanes, one writeback beat per group.
// Optional VLANE_DISPATCH_SKIP_MASKED_EN: fully masked groups skip the writeback beat.
module vector_lane_dispatcher #(
    parameter int NUM_LANES = 2,
    parameter int ELEN      = 32,
    parameter int VLMAX     = 32
) (
    input logic clk,
    input logic rst_n,
    vector_lane_dispatcher_if.master bus
);
    localparam int IDX_W = $clog2(VLMAX);
    localparam int VL_W  = $clog2(VLMAX + 1);
    localparam int IW    = VL_W + 1;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WB, DONE} state_t;
    state_t                    state, state_n;
    logic [VL_W-1:0]           vl_r;
    logic                      mask_en_r;
    logic [VLMAX-1:0]          mask_r;
    logic [IW-1:0]             idx, idx_n, idx_step;
    logic [IW-1:0]             elem [NUM_LANES];
    logic [NUM_LANES-1:0]      active, active_c, got, got_n, fault;
    logic [NUM_LANES*ELEN-1:0] wb_data_r;
    logic                      exception_r, exception_n;
    // Element index is one bit wider than vl so the last group never wraps.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            elem[i]     = idx + IW'(i);
            active_c[i] = (elem[i] < IW'(vl_r)) && (!mask_en_r || mask_r[elem[i][IDX_W-1:0]]);
        end
    end
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        exception_n = exception_r;
        got_n       = got | (bus.lane_done & active);
        fault       = bus.lane_done & active & bus.lane_exception;
        idx_step    = idx + IW'(NUM_LANES);
        case (state)
            IDLE: if (bus.start) begin
                state_n     = (bus.vl == '0) ? DONE : ISSUE;
                idx_n       = '0;
                exception_n = 1'b0;
            end
            ISSUE: begin
                got_n = '0;
`ifdef VLANE_DISPATCH_SKIP_MASKED_EN
                if (active_c == '0) begin
                    idx_n   = idx_step;
                    state_n = (idx_step >= IW'(vl_r)) ? DONE : ISSUE;
                end else state_n = WAIT;
`else
                state_n = (active_c == '0) ? WB : WAIT;
`endif
            end
            WAIT: begin
                if (|fault) begin
                    state_n     = DONE;
                    exception_n = 1'b1;
                end else if (&(got_n | ~active)) state_n = WB;
            end
            WB: if (bus.wb_ready) begin
                idx_n   = idx_step;
                state_n = (idx_step >= IW'(vl_r)) ? DONE : ISSUE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            vl_r        <= '0;
            mask_en_r   <= 1'b0;
            mask_r      <= '0;
            idx         <= '0;
            active      <= '0;
            got         <= '0;
            wb_data_r   <= '0;
            exception_r <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            got         <= got_n;
            exception_r <= exception_n;
            if (state == IDLE && bus.start) begin
                vl_r      <= bus.vl;
                mask_en_r <= bus.mask_en;
                mask_r    <= bus.mask;
            end
            if (state == ISSUE) active <= active_c;
            for (int i = 0; i < NUM_LANES; i++)
                if (state == WAIT && bus.lane_done[i] && active[i])
                    wb_data_r[i*ELEN +: ELEN] <= bus.lane_result[i*ELEN +: ELEN];
        end
    end
    assign bus.busy        = state != IDLE;
    assign bus.done        = state == DONE;
    assign bus.exception   = exception_r;
    assign bus.lane_start  = (state == ISSUE) ? active_c : '0;
    assign bus.wb_valid    = state == WB;
    assign bus.wb_base_idx = idx[IDX_W-1:0];
    assign bus.wb_en       = (state == WB) ? active : '0;
    assign bus.wb_data     = wb_data_r;
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_idx
        assign bus.lane_idx[g*IDX_W +: IDX_W] =
            (state == ISSUE || state == WAIT || state == WB) ? elem[g][IDX_W-1:0] : '0;
    end
endmodule

// File: tb/tb_vector_lane_dispatcher.sv
// tb_vector_lane_dispatcher: directed checks of grouping, masking, latency, exceptions, stalls and reset.
module tb_vector_lane_dispatcher;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    vector_lane_dispatcher_if #(.NUM_LANES(2), .ELEN(32), .VLMAX(32)) bus ();
    vector_lane_dispatcher #(.NUM_LANES(2), .ELEN(32), .VLMAX(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // Entered in the ISSUE cycle; lanes answer one cycle after their start pulse.
    task automatic grp(input string t, input logic [4:0] base, input logic [1:0] en,
                       input logic [31:0] r0, input logic [31:0] r1);
        chk({t, ".start"}, 64'(bus.lane_start), 64'(en));
        chk({t, ".idx"}, 64'(bus.lane_idx), 64'({base + 5'd1, base}));
        tick();
        bus.lane_done   = en;
        bus.lane_result = {r1, r0};
        tick();
        bus.lane_done = 2'b00;
        chk({t, ".valid"}, 64'(bus.wb_valid), 64'd1);
        chk({t, ".base"}, 64'(bus.wb_base_idx), 64'(base));
        chk({t, ".en"}, 64'(bus.wb_en), 64'(en));
        chk({t, ".data"}, bus.wb_data & {{32{en[1]}}, {32{en[0]}}},
            {(en[1] ? r1 : 32'h0), (en[0] ? r0 : 32'h0)});
        tick();
    endtask
    initial begin
        bus.start = 0; bus.vl = 0; bus.mask_en = 0; bus.mask = 0;
        bus.lane_done = 0; bus.lane_result = 0; bus.lane_exception = 0; bus.wb_ready = 1;
        #2;
        chk("rst.busy", 64'(bus.busy), 0);
        chk("rst.done", 64'(bus.done), 0);
        chk("rst.exc", 64'(bus.exception), 0);
        chk("rst.lstart", 64'(bus.lane_start), 0);
        chk("rst.lidx", 64'(bus.lane_idx), 0);
        chk("rst.wbv", 64'(bus.wb_valid), 0);
        chk("rst.wben", 64'(bus.wb_en), 0);
        chk("rst.base", 64'(bus.wb_base_idx), 0);
        chk("rst.data", bus.wb_data, 0);
        #10 rst_n = 1'b1;
        tick();
        // vl=5 unmasked: three beats, last one partial
        bus.vl = 5; bus.start = 1; tick(); bus.start = 0;
        chk("t1.busy", 64'(bus.busy), 1);
        grp("t1g0", 5'd0, 2'b11, 32'hA0, 32'hA1);
        grp("t1g1", 5'd2, 2'b11, 32'hA2, 32'hA3);
        grp("t1g2", 5'd4, 2'b01, 32'hA4, 32'hFF);
        chk("t1.done", 64'(bus.done), 1);
        chk("t1.exc", 64'(bus.exception), 0);
        tick();
        chk("t1.done_pulse", 64'(bus.done), 0);
        chk("t1.idle", 64'(bus.busy), 0);
        // vl=4, lane1 answers five cycles after lane0
        bus.vl = 4; bus.start = 1; tick(); bus.start = 0;
        chk("t2.start", 64'(bus.lane_start), 64'b11);
        tick();
        bus.lane_done = 2'b01; bus.lane_result = {32'hDEAD, 32'hB0};
        tick();
        bus.lane_done = 2'b00;
        for (int k = 0; k < 4; k++) begin
            chk("t2.wait_nowb", 64'(bus.wb_valid), 0);
            tick();
        end
        bus.lane_done = 2'b10; bus.lane_result = {32'hB1, 32'hBEEF};
        tick();
        bus.lane_done = 2'b00;
        chk("t2.valid", 64'(bus.wb_valid), 1);
        chk("t2.en", 64'(bus.wb_en), 64'b11);
        chk("t2.data", bus.wb_data, {32'hB1, 32'hB0});
        tick();
        grp("t2g1", 5'd2, 2'b11, 32'hB2, 32'hB3);
        chk("t2.done", 64'(bus.done), 1);
        tick();
        // mask 0x5: elements 0 and 2 only
        bus.vl = 4; bus.mask_en = 1; bus.mask = 32'h5; bus.start = 1; tick(); bus.start = 0;
        grp("t3g0", 5'd0, 2'b01, 32'hC0, 32'h0);
        grp("t3g1", 5'd2, 2'b01, 32'hC2, 32'h0);
        chk("t3.done", 64'(bus.done), 1);
        tick();
        // mask 0x1: second group fully masked still gets an empty beat
        bus.mask = 32'h1; bus.start = 1; tick(); bus.start = 0;
        grp("t3bg0", 5'd0, 2'b01, 32'hD0, 32'h0);
        chk("t3b.nostart", 64'(bus.lane_start), 0);
        tick();
        chk("t3b.valid", 64'(bus.wb_valid), 1);
        chk("t3b.en", 64'(bus.wb_en), 0);
        chk("t3b.base", 64'(bus.wb_base_idx), 2);
        tick();
        chk("t3b.done", 64'(bus.done), 1);
        bus.mask_en = 0;
        tick();
        // vl=0 goes straight to DONE
        bus.vl = 0; bus.start = 1; tick(); bus.start = 0;
        chk("t4.done", 64'(bus.done), 1);
        chk("t4.lstart", 64'(bus.lane_start), 0);
        chk("t4.wbv", 64'(bus.wb_valid), 0);
        tick();
        chk("t4.idle", 64'(bus.busy), 0);
        // vl=8, exception in the second group
        bus.vl = 8; bus.start = 1; tick(); bus.start = 0;
        grp("t5g0", 5'd0, 2'b11, 32'hE0, 32'hE1);
        chk("t5.start", 64'(bus.lane_start), 64'b11);
        tick();
        bus.lane_done = 2'b11; bus.lane_exception = 2'b10; bus.lane_result = {32'hE3, 32'hE2};
        tick();
        bus.lane_done = 2'b00; bus.lane_exception = 2'b00;
        chk("t5.done", 64'(bus.done), 1);
        chk("t5.exc", 64'(bus.exception), 1);
        chk("t5.nowb", 64'(bus.wb_valid), 0);
        tick();
        chk("t5.exc_hold", 64'(bus.exception), 1);
        bus.vl = 0; bus.start = 1; tick(); bus.start = 0;
        chk("t5.exc_clr", 64'(bus.exception), 0);
        chk("t5.done2", 64'(bus.done), 1);
        tick();
        // wb_ready stall, plus start pulses while busy
        bus.vl = 2; bus.start = 1; tick(); bus.start = 0;
        tick();
        bus.lane_done = 2'b11; bus.lane_result = {32'hF1, 32'hF0};
        bus.wb_ready = 0; bus.start = 1; bus.vl = 4;
        tick();
        bus.lane_done = 2'b00;
        for (int k = 0; k < 5; k++) begin
            chk("t6.valid", 64'(bus.wb_valid), 1);
            chk("t6.en", 64'(bus.wb_en), 64'b11);
            chk("t6.data", bus.wb_data, {32'hF1, 32'hF0});
            chk("t6.base", 64'(bus.wb_base_idx), 0);
            if (k == 4) bus.wb_ready = 1;
            tick();
        end
        chk("t6.done", 64'(bus.done), 1);
        bus.start = 0;
        tick();
        chk("t6.idle", 64'(bus.busy), 0);
        // asynchronous reset in the middle of WAIT
        bus.vl = 4; bus.start = 1; tick(); bus.start = 0;
        tick();
        chk("t7.inwait", 64'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("t7.busy", 64'(bus.busy), 0);
        chk("t7.lstart", 64'(bus.lane_start), 0);
        chk("t7.lidx", 64'(bus.lane_idx), 0);
        chk("t7.wbv", 64'(bus.wb_valid), 0);
        chk("t7.data", bus.wb_data, 0);
        chk("t7.done", 64'(bus.done), 0);
        #3 rst_n = 1'b1;
        tick();
        chk("t7.idle", 64'(bus.busy), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
